controlador_jogo: RTL and testbench
===================================

# controlador_jogo

Game-mode controller that sequences the 4-digit seven-segment display multiplexer. It turns debounced button levels into one-hot mode lines (`DESLIGADO`/`PREPARACAO`/`ATAQUE`), plus map and column/row selections that feed the display directly. It also produces the display scan-rate enable and a shot pulse for downstream game logic. It sits between the debounced button inputs and the display/board logic.

## Interface
- `TICK_DIV`, 50000: clocks per display scan tick; must be ≥ 2.
- `N_MAPAS`, 5: number of selectable maps (1..8); `mapa` ranges 0..N_MAPAS-1.
- `MAX_TIROS`, 10: shot limit used only with `LIMITE_TIROS_EN`; 1..15.

- `clock`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `btn_liga`  in  1  debounced level: power toggle.
- `btn_confirma`  in  1  debounced level: confirm map / fire.
- `btn_avanca`  in  1  debounced level: next map (PREPARACAO) / next column (ATAQUE).
- `btn_linha`  in  1  debounced level: next row (ATAQUE).
- `DESLIGADO`, `PREPARACAO`, `ATAQUE`  out  1 each  one-hot mode.
- `mapa`  out  3  selected map.
- `coordColuna`, `coordLinha`  out  3 each  attack coordinates.
- `tiro_valido`  out  1  one-cycle pulse per accepted shot.
- `tiros`  out  4  shots fired this game.
- `tick_varredura`  out  1  one-cycle pulse every `TICK_DIV` clocks; display scan-counter enable.

## Operation
- A press is a rising edge: the input is high this sample and its registered previous sample is low. Previous-sample registers reset to 1, so a button held through reset produces no press.
- Reset (`reset_n`=0 at an edge): `DESLIGADO`=1, `PREPARACAO`=`ATAQUE`=0, `mapa`=`coordColuna`=`coordLinha`=0, `tiros`=0, `tiro_valido`=0, `tick_varredura`=0, scan counter=0. Reset mid-game aborts immediately.
- FSM states are DESLIGADO, PREPARACAO and ATAQUE. Exactly one mode output is high at all times.
  - DESLIGADO:
    - `liga` → PREPARACAO.
    - Entering PREPARACAO clears `mapa`, coordinates and `tiros`.
    - All other presses are ignored.
  - PREPARACAO:
    - `liga` → DESLIGADO.
    - Otherwise `confirma` → ATAQUE; coordinates are cleared to 0.
    - Otherwise `avanca` → `mapa`+1, wrapping N_MAPAS-1 → 0.
    - `linha` is ignored.
  - ATAQUE:
    - `liga` → DESLIGADO; `mapa`, coordinates and `tiros` hold their values.
    - Otherwise `confirma` → `tiro_valido`=1 for one cycle; `tiros`+1, saturating at 15.
    - Otherwise `avanca` and/or `linha` → `coordColuna`+1 and/or `coordLinha`+1, each wrapping 7 → 0. Both may apply in the same cycle.
- Simultaneous presses are resolved by priority: `liga` > `confirma` > `avanca`/`linha`. Lower-priority presses in the same cycle are discarded, not deferred.
- Scan counter:
  - Free-runs 0..TICK_DIV-1 in every state.
  - `tick_varredura`=1 in the cycle the counter equals TICK_DIV-1, then the counter wraps to 0.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A press sampled at edge k updates state, counters and `tiro_valido` at edge k. Outputs are therefore valid one clock after the input rises before edge k.
- `tiro_valido` is high for exactly one cycle. Any press re-arms only after the button has been sampled low.
- First `tick_varredura` pulse follows the TICK_DIV-th edge after reset release; subsequent pulses are exactly TICK_DIV clocks apart.

## Configuration
- `LIMITE_TIROS_EN` defined:
  - On the `confirma` that brings `tiros` to MAX_TIROS, `tiro_valido` pulses and the FSM moves to DESLIGADO on the same edge.
  - `tiros` holds MAX_TIROS until the next `liga`.
- `LIMITE_TIROS_EN` undefined: no automatic power-off; `tiros` saturates at 15.

## Test plan
- Reset with `btn_liga` held high, then release → `DESLIGADO`=1, all counts 0, no transition.
- `liga` press, then 6 `avanca` presses (N_MAPAS=5) → `PREPARACAO`=1, `mapa`=1 (0→4→0→1).
- In PREPARACAO, press `confirma` and `avanca` in the same cycle → `ATAQUE`=1, `mapa` unchanged, coordinates 0.
- In ATAQUE, 9 simultaneous `avanca`+`linha` presses, then 1 `confirma` → coordinates (1,1), exactly one `tiro_valido` pulse, `tiros`=1.
- With `LIMITE_TIROS_EN` and MAX_TIROS=3, fire 3 shots → third pulse coincides with `DESLIGADO`=1 and `tiros`=3; without the macro, 17 shots → `tiros`=15 and still in ATAQUE.
- With TICK_DIV=4, run 12 clocks after reset → `tick_varredura` pulses at edges 4, 8 and 12 only; `reset_n` low mid-ATAQUE → all outputs at reset values the next edge.

Source files
------------

// File: rtl/controlador_jogo.sv
// rtl/controlador_jogo.sv - game-mode controller for the 4-digit seven-segment display
//
// Parameters:
//   TICK_DIV   clocks per display scan tick (>= 2)
//   N_MAPAS    selectable maps, 1..8
//   MAX_TIROS  shot limit, 1..15, active only when LIMITE_TIROS_EN is defined
// Build macro:
//   LIMITE_TIROS_EN  power off automatically on the shot that reaches MAX_TIROS
// Ports:
//   clock, reset_n                       rising-edge clock, synchronous active-low reset
//   btn_liga/confirma/avanca/linha       debounced button levels
//   DESLIGADO, PREPARACAO, ATAQUE        one-hot mode
//   mapa, coordColuna, coordLinha        map and attack coordinates
//   tiro_valido, tiros                   shot pulse and shot count
//   tick_varredura                       one-cycle scan enable every TICK_DIV clocks
module controlador_jogo #(
  parameter int TICK_DIV  = 50000,
  parameter int N_MAPAS   = 5,
  parameter int MAX_TIROS = 10
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       btn_liga,
  input  logic       btn_confirma,
  input  logic       btn_avanca,
  input  logic       btn_linha,
  output logic       DESLIGADO,
  output logic       PREPARACAO,
  output logic       ATAQUE,
  output logic [2:0] mapa,
  output logic [2:0] coordColuna,
  output logic [2:0] coordLinha,
  output logic       tiro_valido,
  output logic [3:0] tiros,
  output logic       tick_varredura
);

  localparam int CW = $clog2(TICK_DIV);

`ifdef LIMITE_TIROS_EN
  localparam bit LIMITE_EN = 1'b1;
`else
  localparam bit LIMITE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_DESLIGADO  = 3'b001,
    S_PREPARACAO = 3'b010,
    S_ATAQUE     = 3'b100
  } estado_t;

  estado_t         estado_q, estado_d;
  logic [3:0]      btn_prev_q, btn_prev_d;  // {linha, avanca, confirma, liga}
  logic [2:0]      mapa_q, mapa_d;
  logic [2:0]      col_q, col_d;
  logic [2:0]      lin_q, lin_d;
  logic [3:0]      tiros_q, tiros_d;
  logic            tiro_valido_q, tiro_valido_d;
  logic            tick_q, tick_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [3:0]      btn_now;
  logic [3:0]      press;
  logic [3:0]      tiros_inc;

  always_comb begin
    btn_now   = {btn_linha, btn_avanca, btn_confirma, btn_liga};
    press     = btn_now & ~btn_prev_q;
    tiros_inc = (tiros_q == 4'hF) ? tiros_q : tiros_q + 4'd1;

    estado_d      = estado_q;
    btn_prev_d    = btn_now;
    mapa_d        = mapa_q;
    col_d         = col_q;
    lin_d         = lin_q;
    tiros_d       = tiros_q;
    tiro_valido_d = 1'b0;

    // Scan counter runs regardless of mode; tick is registered on the wrap edge.
    if (cnt_q == CW'(TICK_DIV - 1)) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 1'b1;
      tick_d = 1'b0;
    end

    // Priority liga > confirma > avanca/linha; losers are dropped, not queued.
    case (estado_q)
      S_DESLIGADO: begin
        if (press[0]) begin
          estado_d = S_PREPARACAO;
          mapa_d   = '0;
          col_d    = '0;
          lin_d    = '0;
          tiros_d  = '0;
        end
      end
      S_PREPARACAO: begin
        if (press[0]) begin
          estado_d = S_DESLIGADO;
        end else if (press[1]) begin
          estado_d = S_ATAQUE;
          col_d    = '0;
          lin_d    = '0;
        end else if (press[2]) begin
          mapa_d = (mapa_q == 3'(N_MAPAS - 1)) ? 3'd0 : mapa_q + 3'd1;
        end
      end
      S_ATAQUE: begin
        if (press[0]) begin
          estado_d = S_DESLIGADO;
        end else if (press[1]) begin
          tiro_valido_d = 1'b1;
          tiros_d       = tiros_inc;
          if (LIMITE_EN && (tiros_inc == 4'(MAX_TIROS))) begin
            estado_d = S_DESLIGADO;
          end
        end else begin
          // 3-bit coordinates wrap 7 -> 0 on their own.
          if (press[2]) col_d = col_q + 3'd1;
          if (press[3]) lin_d = lin_q + 3'd1;
        end
      end
      default: estado_d = S_DESLIGADO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q      <= S_DESLIGADO;
      btn_prev_q    <= 4'hF;  // a button held through reset is not a press
      mapa_q        <= '0;
      col_q         <= '0;
      lin_q         <= '0;
      tiros_q       <= '0;
      tiro_valido_q <= 1'b0;
      tick_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      estado_q      <= estado_d;
      btn_prev_q    <= btn_prev_d;
      mapa_q        <= mapa_d;
      col_q         <= col_d;
      lin_q         <= lin_d;
      tiros_q       <= tiros_d;
      tiro_valido_q <= tiro_valido_d;
      tick_q        <= tick_d;
      cnt_q         <= cnt_d;
    end
  end

  assign DESLIGADO      = (estado_q == S_DESLIGADO);
  assign PREPARACAO     = (estado_q == S_PREPARACAO);
  assign ATAQUE         = (estado_q == S_ATAQUE);
  assign mapa           = mapa_q;
  assign coordColuna    = col_q;
  assign coordLinha     = lin_q;
  assign tiro_valido    = tiro_valido_q;
  assign tiros          = tiros_q;
  assign tick_varredura = tick_q;

endmodule

// File: tb/tb_controlador_jogo.sv
// tb/tb_controlador_jogo.sv - self-checking bench for controlador_jogo
module tb_controlador_jogo;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_liga = 1'b0, btn_confirma = 1'b0, btn_avanca = 1'b0, btn_linha = 1'b0;
  logic       DESLIGADO, PREPARACAO, ATAQUE;
  logic [2:0] mapa, coordColuna, coordLinha;
  logic       tiro_valido;
  logic [3:0] tiros;
  logic       tick_varredura;

  controlador_jogo #(.TICK_DIV(4), .N_MAPAS(5), .MAX_TIROS(3)) dut (
    .clock(clock), .reset_n(reset_n),
    .btn_liga(btn_liga), .btn_confirma(btn_confirma),
    .btn_avanca(btn_avanca), .btn_linha(btn_linha),
    .DESLIGADO(DESLIGADO), .PREPARACAO(PREPARACAO), .ATAQUE(ATAQUE),
    .mapa(mapa), .coordColuna(coordColuna), .coordLinha(coordLinha),
    .tiro_valido(tiro_valido), .tiros(tiros), .tick_varredura(tick_varredura)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] modo;   // {ATAQUE, PREPARACAO, DESLIGADO}
    logic [2:0] mapa;
    logic [2:0] col;
    logic [2:0] lin;
    logic       tv;
    logic [3:0] tiros;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;
  int   tv_count = 0;
  logic [11:0] tick_hist;

  // Reference model state (mode: 0 off, 1 preparation, 2 attack)
  int         m_modo, m_mapa, m_col, m_lin, m_tiros, m_n;
  logic       m_tv;
  logic [3:0] m_prev;

  task automatic check(input string tag, input int obs, input int expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input logic rn, input logic [3:0] b);
    logic [3:0] p;
    if (!rn) begin
      m_modo = 0; m_mapa = 0; m_col = 0; m_lin = 0; m_tiros = 0;
      m_tv = 1'b0; m_prev = 4'hF; m_n = 0;
    end else begin
      p = b & ~m_prev;
      m_prev = b;
      m_n++;
      m_tv = 1'b0;
      if (m_modo == 0) begin
        if (p[0]) begin
          m_modo = 1; m_mapa = 0; m_col = 0; m_lin = 0; m_tiros = 0;
        end
      end else if (m_modo == 1) begin
        if (p[0]) m_modo = 0;
        else if (p[1]) begin m_modo = 2; m_col = 0; m_lin = 0; end
        else if (p[2]) m_mapa = (m_mapa + 1) % 5;
      end else begin
        if (p[0]) m_modo = 0;
        else if (p[1]) begin
          m_tv = 1'b1;
          if (m_tiros < 15) m_tiros++;
`ifdef LIMITE_TIROS_EN
          if (m_tiros == 3) m_modo = 0;
`endif
        end else begin
          if (p[2]) m_col = (m_col + 1) % 8;
          if (p[3]) m_lin = (m_lin + 1) % 8;
        end
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.modo  = {m_modo == 2, m_modo == 1, m_modo == 0};
    e.mapa  = 3'(m_mapa);
    e.col   = 3'(m_col);
    e.lin   = 3'(m_lin);
    e.tv    = m_tv;
    e.tiros = 4'(m_tiros);
    e.tick  = (m_n != 0) && (m_n % 4 == 0);
    return e;
  endfunction

  // b = {linha, avanca, confirma, liga}
  task automatic step(input logic rn, input logic [3:0] b);
    exp_t e;
    @(negedge clock);
    reset_n = rn;
    btn_liga = b[0]; btn_confirma = b[1]; btn_avanca = b[2]; btn_linha = b[3];
    model(rn, b);
    sb.push_back(model_out());
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("modo", int'({ATAQUE, PREPARACAO, DESLIGADO}), int'(e.modo));
    check("mapa", int'(mapa), int'(e.mapa));
    check("coordColuna", int'(coordColuna), int'(e.col));
    check("coordLinha", int'(coordLinha), int'(e.lin));
    check("tiro_valido", int'(tiro_valido), int'(e.tv));
    check("tiros", int'(tiros), int'(e.tiros));
    check("tick_varredura", int'(tick_varredura), int'(e.tick));
    if (tiro_valido === 1'b1) tv_count++;
  endtask

  task automatic press(input logic [3:0] b);
    step(1'b1, b);
    step(1'b1, 4'b0000);
  endtask

  initial begin
    // Reset with liga held, then release still holding it: no transition.
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0001);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, (i == 0) ? 4'b0001 : 4'b0000);
      tick_hist[i] = tick_varredura;
    end
    check("tick_pattern", int'(tick_hist), int'(12'b1000_1000_1000));
    check("held_liga_off", int'(DESLIGADO), 1);

    // Power on, six map advances with linha ignored in between.
    press(4'b0001);
    check("prep_mode", int'(PREPARACAO), 1);
    for (int i = 0; i < 6; i++) press(4'b0100);
    press(4'b1000);
    check("mapa_wrap", int'(mapa), 1);

    // Confirm and advance together: confirm wins.
    press(4'b0110);
    check("ataque_mode", int'(ATAQUE), 1);
    check("mapa_kept", int'(mapa), 1);

    // Nine joint column/row steps wrap to (1,1), then one shot.
    for (int i = 0; i < 9; i++) press(4'b1100);
    check("col_9", int'(coordColuna), 1);
    check("lin_9", int'(coordLinha), 1);
    tv_count = 0;
    press(4'b0010);
    check("one_pulse", tv_count, 1);
    check("tiros_1", int'(tiros), 1);

`ifdef LIMITE_TIROS_EN
    press(4'b0010);
    step(1'b1, 4'b0010);
    check("limit_pulse", int'(tiro_valido), 1);
    check("limit_off", int'(DESLIGADO), 1);
    check("limit_tiros", int'(tiros), 3);
    step(1'b1, 4'b0000);
`else
    for (int i = 0; i < 16; i++) press(4'b0010);
    check("tiros_sat", int'(tiros), 15);
    check("still_ataque", int'(ATAQUE), 1);
    // Power off holds values.
    press(4'b0001);
    check("off_hold_col", int'(coordColuna), 1);
`endif

    // Power on again clears, reach attack, then reset mid-game.
    press(4'b0001);
    check("reentry_tiros", int'(tiros), 0);
    press(4'b0010);
    press(4'b0100);
    check("ataque_again", int'(ATAQUE), 1);
    step(1'b0, 4'b0110);
    check("reset_desl", int'(DESLIGADO), 1);
    check("reset_col", int'(coordColuna), 0);
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
